// File: rtl/spi_pwm_cfg_ctrl.sv
// spi_pwm_cfg_ctrl: SPI command parser with shadow/active PWM divider and duty registers.
// Optional SPI_PWM_CFG_READBACK_EN shifts the pre-write shadow value out on spi_miso.
module spi_pwm_cfg_ctrl #(
    parameter int NUM_CH           = 4,
    parameter int CLOCK_DIV_WIDTH  = 32,
    parameter int DUTY_CYCLE_WIDTH = 8
) (
    input  logic                                 rst,
    input  logic                                 spi_sclk,
    input  logic                                 spi_cs,
    input  logic                                 spi_mosi,
    output logic                                 spi_miso,
    output logic [NUM_CH*CLOCK_DIV_WIDTH-1:0]    cfg_div,
    output logic [NUM_CH*DUTY_CYCLE_WIDTH-1:0]   cfg_duty,
    output logic [NUM_CH-1:0]                    cfg_toggle,
    output logic                                 err_flag
);
    localparam int CW    = CLOCK_DIV_WIDTH;
    localparam int DW    = DUTY_CYCLE_WIDTH;
    localparam int CNT_W = $clog2(CW + 1);

    typedef enum logic [1:0] {IDLE, CMD, PAYLOAD, ERROR} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, plen;
    logic [7:0]       cmd_q, cmd_full;
    logic [CW-1:0]    pay_q, pay_full;
    logic [1:0]       op_q;
    logic [3:0]       ch_q;
    logic [15:0]      mask;
    logic             illegal, decode, last, err_q;
    logic [CW-1:0]    sh_div_q  [NUM_CH];
    logic [CW-1:0]    act_div_q [NUM_CH];
    logic [DW-1:0]    sh_duty_q [NUM_CH];
    logic [DW-1:0]    act_duty_q[NUM_CH];
    logic [NUM_CH-1:0] tog_q;

    // Both shifters fill from the top, so the newest bits sit MSB-aligned.
    assign cmd_full = {spi_mosi, cmd_q[7:1]};
    assign pay_full = {spi_mosi, pay_q[CW-1:1]};
    assign mask     = 16'(pay_full[CW-1 -: 8]);
    assign illegal  = cmd_full[3:2] != 2'b00 ||
                      ((cmd_full[1] ^ cmd_full[0]) && int'(cmd_full[7:4]) >= NUM_CH);
    assign plen     = CNT_W'(op_q == 2'b01 ? CW : op_q == 2'b10 ? DW : 8);
    assign decode   = state_q == CMD && cnt_q == CNT_W'(7);
    assign last     = state_q == PAYLOAD && cnt_q == plen - CNT_W'(1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        unique case (state_q)
            IDLE:    state_d = CMD;
            CMD: begin
                state_d = decode ? (illegal ? ERROR : cmd_full[1:0] == 2'b00 ? IDLE : PAYLOAD) : CMD;
                cnt_d   = decode ? '0 : cnt_d;
            end
            PAYLOAD: begin
                state_d = last ? IDLE : PAYLOAD;
                cnt_d   = last ? '0 : cnt_d;
            end
            ERROR:   cnt_d = cnt_q;
        endcase
    end

    // Chip-select high abandons any partial frame without touching register state.
    always_ff @(posedge spi_sclk or negedge rst or posedge spi_cs) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else if (spi_cs) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef SPI_PWM_CFG_READBACK_EN
    logic [CW-1:0] rb_q, rb_val;

    always_comb begin
        rb_val = '0;
        for (int c = 0; c < NUM_CH; c++)
            if (cmd_full[7:4] == 4'(c))
                rb_val = cmd_full[1:0] == 2'b01 ? sh_div_q[c] : CW'(sh_duty_q[c]);
    end

    assign spi_miso = state_q == PAYLOAD && op_q != 2'b11 ? rb_q[0] : 1'b0;
`else
    assign spi_miso = spi_mosi;
`endif

    always_ff @(posedge spi_sclk or negedge rst) begin
        if (!rst) begin
            cmd_q <= '0;
            pay_q <= '0;
            op_q  <= '0;
            ch_q  <= '0;
            err_q <= 1'b0;
            tog_q <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                sh_div_q[c]   <= '0;
                act_div_q[c]  <= '0;
                sh_duty_q[c]  <= '0;
                act_duty_q[c] <= '0;
            end
`ifdef SPI_PWM_CFG_READBACK_EN
            rb_q <= '0;
`endif
        end else begin
            cmd_q <= cmd_full;
            pay_q <= pay_full;
            if (decode) begin
                op_q <= cmd_full[1:0];
                ch_q <= cmd_full[7:4];
            end
            if (decode && illegal)
                err_q <= 1'b1;
            else if (decode && cmd_full == 8'hF0)
                err_q <= 1'b0;
            for (int c = 0; c < NUM_CH; c++) begin
                if (last && op_q == 2'b01 && ch_q == 4'(c))
                    sh_div_q[c] <= pay_full;
                if (last && op_q == 2'b10 && ch_q == 4'(c))
                    sh_duty_q[c] <= pay_full[CW-1 -: DW];
                if (last && op_q == 2'b11 && mask[c]) begin
                    act_div_q[c]  <= sh_div_q[c];
                    act_duty_q[c] <= sh_duty_q[c];
                    tog_q[c]      <= ~tog_q[c];
                end
            end
`ifdef SPI_PWM_CFG_READBACK_EN
            rb_q <= decode ? rb_val : rb_q >> 1;
`endif
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_pack
        assign cfg_div[i*CW +: CW]  = act_div_q[i];
        assign cfg_duty[i*DW +: DW] = act_duty_q[i];
    end

    assign cfg_toggle = tog_q;
    assign err_flag   = err_q;
endmodule

// File: tb/tb_spi_pwm_cfg_ctrl.sv
// tb_spi_pwm_cfg_ctrl: directed and random SPI frames checked against a register-level model.
module tb_spi_pwm_cfg_ctrl;
    localparam int NUM_CH = 4;
    localparam int CW     = 32;
    localparam int DW     = 8;

    logic rst, clk, cs, mosi;
    logic miso;
    logic [NUM_CH*CW-1:0] div;
    logic [NUM_CH*DW-1:0] duty;
    logic [NUM_CH-1:0]    tog;
    logic                 err;

    spi_pwm_cfg_ctrl #(.NUM_CH(NUM_CH), .CLOCK_DIV_WIDTH(CW), .DUTY_CYCLE_WIDTH(DW)) dut (
        .rst(rst), .spi_sclk(clk), .spi_cs(cs), .spi_mosi(mosi), .spi_miso(miso),
        .cfg_div(div), .cfg_duty(duty), .cfg_toggle(tog), .err_flag(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [CW-1:0]     m_sdiv [NUM_CH];
    logic [CW-1:0]     m_adiv [NUM_CH];
    logic [DW-1:0]     m_sduty[NUM_CH];
    logic [DW-1:0]     m_aduty[NUM_CH];
    logic [NUM_CH-1:0] m_tog;
    logic              m_err, m_lock;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [NUM_CH*CW-1:0] ediv;
        logic [NUM_CH*DW-1:0] eduty;
        for (int i = 0; i < NUM_CH; i++) begin
            ediv[i*CW +: CW]  = m_adiv[i];
            eduty[i*DW +: DW] = m_aduty[i];
        end
        chk({tag, "_div"}, 128'(div), 128'(ediv));
        chk({tag, "_duty"}, 128'(duty), 128'(eduty));
        chk({tag, "_toggle"}, 128'(tog), 128'(m_tog));
        chk({tag, "_err"}, 128'(err), 128'(m_err));
    endtask

    // Readback output is sampled on the falling edge, just before the next bit is driven.
    task automatic send_bit(input logic b, input logic rb_on, input logic rb_exp);
        @(negedge clk);
`ifdef SPI_PWM_CFG_READBACK_EN
        chk("miso", 128'(miso), 128'(rb_on ? rb_exp : 1'b0));
`endif
        cs   = 1'b0;
        mosi = b;
`ifndef SPI_PWM_CFG_READBACK_EN
        #1 chk("loopback", 128'(miso), 128'(b));
`endif
    endtask

    task automatic end_frame();
        @(negedge clk);
        cs     = 1'b1;
        mosi   = 1'b0;
        m_lock = 1'b0;
        @(negedge clk);
    endtask

    // pbits < 0 sends the full payload; otherwise only that many payload bits.
    task automatic do_frame(input logic [7:0] cmd, input logic [CW-1:0] pay, input int pbits);
        int  op, ch, plen, n;
        logic bad, active, rb;
        logic [CW-1:0] old;
        op     = int'(cmd[1:0]);
        ch     = int'(cmd[7:4]);
        plen   = op == 1 ? CW : op == 2 ? DW : op == 3 ? 8 : 0;
        bad    = cmd[3:2] != 2'b00 || ((op == 1 || op == 2) && ch >= NUM_CH);
        active = !m_lock;
        for (int i = 0; i < 8; i++) send_bit(cmd[i], 1'b0, 1'b0);
        if (active && bad) begin
            m_err  = 1'b1;
            m_lock = 1'b1;
        end else if (active && cmd == 8'hF0)
            m_err = 1'b0;
        n   = pbits < 0 ? plen : pbits;
        rb  = active && !bad && (op == 1 || op == 2);
        old = '0;
        if (rb) old = op == 1 ? m_sdiv[ch] : CW'(m_sduty[ch]);
        for (int i = 0; i < n; i++) send_bit(pay[i], rb, old[i]);
        if (active && !bad && n == plen) begin
            if (op == 1) m_sdiv[ch] = pay;
            if (op == 2) m_sduty[ch] = pay[DW-1:0];
            if (op == 3)
                for (int i = 0; i < NUM_CH; i++)
                    if (pay[i]) begin
                        m_adiv[i]  = m_sdiv[i];
                        m_aduty[i] = m_sduty[i];
                        m_tog[i]   = ~m_tog[i];
                    end
        end
    endtask

    initial begin
        for (int i = 0; i < NUM_CH; i++) begin
            m_sdiv[i] = '0; m_adiv[i] = '0; m_sduty[i] = '0; m_aduty[i] = '0;
        end
        m_tog = '0; m_err = 1'b0; m_lock = 1'b0;
        rst = 1'b0; cs = 1'b1; mosi = 1'b0;
        repeat (3) @(negedge clk);
        check_all("reset");
        chk("reset_miso", 128'(miso), 128'(0));
        rst = 1'b1;
        @(negedge clk);

        do_frame(8'h11, 32'h0000_03E8, -1);
        do_frame(8'h12, 32'h80, -1);
        do_frame(8'h03, 32'h02, -1);
        end_frame();
        check_all("burst");
        chk("ch1_div", 128'(div[63:32]), 128'(1000));
        chk("ch1_duty", 128'(duty[15:8]), 128'(8'h80));
        chk("burst_tog", 128'(tog), 128'(4'b0010));

        do_frame(8'h02, 32'h40, -1);
        end_frame();
        check_all("shadow_only");
        chk("ch0_duty_hold", 128'(duty[7:0]), 128'(0));
        do_frame(8'h03, 32'hFF, -1);
        end_frame();
        check_all("commit_all");
        chk("ch0_duty", 128'(duty[7:0]), 128'(8'h40));
        chk("all_tog", 128'(tog), 128'(4'b1101));

        do_frame(8'h55, 32'h0, 0);
        do_frame(8'h22, 32'h12, -1);
        end_frame();
        check_all("reserved");
        chk("err_set", 128'(err), 128'(1));
        do_frame(8'hF0, 32'h0, -1);
        end_frame();
        check_all("err_clr");
        chk("err_clear", 128'(err), 128'(0));

        do_frame(8'h21, 32'hFFFF_FFFF, 20);
        end_frame();
        do_frame(8'h03, 32'h04, -1);
        end_frame();
        check_all("trunc");
        chk("ch2_div_zero", 128'(div[95:64]), 128'(0));
        do_frame(8'h21, 32'd77, -1);
        do_frame(8'h03, 32'h04, -1);
        end_frame();
        check_all("after_trunc");
        chk("ch2_div", 128'(div[95:64]), 128'(77));

        do_frame(8'h31, 32'hA5A5_A5A5, -1);
        end_frame();
        do_frame(8'h31, 32'h0, -1);
        end_frame();
        check_all("readback");

        do_frame(8'h51, 32'h1234, -1);
        end_frame();
        check_all("bad_ch");
        do_frame(8'h30, 32'h0, -1);
        end_frame();
        check_all("nop_keep_err");
        do_frame(8'hF0, 32'h0, -1);
        end_frame();
        check_all("err_clr2");

        for (int k = 0; k < 60; k++) begin
            int op, chn, plen, pb;
            logic [1:0] res;
            op   = int'($urandom_range(0, 3));
            chn  = $urandom_range(0, 7) == 0 ? 15 : int'($urandom_range(0, NUM_CH));
            res  = $urandom_range(0, 9) == 0 ? 2'($urandom_range(1, 3)) : 2'b00;
            plen = op == 1 ? CW : op == 2 ? DW : 8;
            pb   = (op != 0 && $urandom_range(0, 7) == 0) ? int'($urandom_range(0, plen - 1)) : -1;
            do_frame({4'(chn), res, 2'(op)}, $urandom, pb);
            if (pb >= 0 || $urandom_range(0, 1) == 1) begin
                end_frame();
                check_all("rnd");
            end
        end
        end_frame();
        check_all("final");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
